// File: rtl/vend_pkg.sv
// Shared state type and coin/credit constants for the vending controller.
package vend_pkg;
  localparam int CREDIT_W = 7;

  localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(25);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_VEND,
    ST_CHANGE
  } state_t;
endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus rising-edge detector producing a one-cycle PULSE.
// An input already high when reset releases is ignored until it has been seen low.
module edge_sync (
  input  logic CLK50M,
  input  logic nRST,
  input  logic A,
  output logic PULSE
);
  logic       sync1;
  logic       sync2;
  logic       prev;
  logic       armed;
  logic [1:0] fill;

  always_ff @(posedge CLK50M or negedge nRST) begin
    if (!nRST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
      fill  <= 2'b00;
    end else begin
      sync1 <= A;
      sync2 <= sync1;
      prev  <= sync2;
      fill  <= {fill[0], 1'b1};
      // Arm only once sync2 holds a genuine pin sample that is low.
      armed <= armed | (fill[1] & ~sync2);
    end
  end

  assign PULSE = sync2 & ~prev & armed;
endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending controller: accumulates credit, vends at PRICE, returns change.
// Optional change return is enabled with the CHANGE_RETURN_EN macro.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE   = 35,
  parameter int RET_GAP = 3
) (
  input  logic                CLK50M,
  input  logic                nRST,
  input  logic                NICKEL,
  input  logic                DIME,
  input  logic                QUARTER,
  input  logic                CANCEL,
  output logic                VEND,
  output logic                RET_NICKEL,
  output logic                RET_DIME,
  output logic [CREDIT_W-1:0] CREDIT,
  output logic                BUSY
);
  localparam logic [CREDIT_W:0] PRICE_V = (CREDIT_W + 1)'(PRICE);

  if (PRICE < 5 || PRICE > 100 || (PRICE % 5) != 0) begin : g_bad_price
    $error("vend_controller: PRICE must be a multiple of 5 in 5..100");
  end
  if (RET_GAP < 1 || RET_GAP > 15) begin : g_bad_gap
    $error("vend_controller: RET_GAP must be in 1..15");
  end

  logic [3:0] level;
  logic [3:0] pulse;

  assign level = {CANCEL, QUARTER, DIME, NICKEL};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    edge_sync u_sync (
      .CLK50M (CLK50M),
      .nRST   (nRST),
      .A      (level[gi]),
      .PULSE  (pulse[gi])
    );
  end

  logic                coin_ev;
  logic                cancel_ev;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;

  // Simultaneous coins: only the most valuable one counts.
  always_comb begin
    coin_ev  = 1'b1;
    coin_val = '0;
    if (pulse[2])      coin_val = QUARTER_C;
    else if (pulse[1]) coin_val = DIME_C;
    else if (pulse[0]) coin_val = NICKEL_C;
    else               coin_ev  = 1'b0;
  end

  assign cancel_ev = pulse[3];
  assign sum       = {1'b0, CREDIT} + {1'b0, coin_val};

  state_t state;

`ifdef CHANGE_RETURN_EN
  logic [3:0]          gap;
  logic [CREDIT_W-1:0] ret_val;

  assign ret_val = (CREDIT >= DIME_C) ? DIME_C : NICKEL_C;
`else
  assign RET_NICKEL = 1'b0;
  assign RET_DIME   = 1'b0;
`endif

  always_ff @(posedge CLK50M or negedge nRST) begin
    if (!nRST) begin
      state  <= ST_IDLE;
      CREDIT <= '0;
      VEND   <= 1'b0;
      BUSY   <= 1'b0;
`ifdef CHANGE_RETURN_EN
      RET_NICKEL <= 1'b0;
      RET_DIME   <= 1'b0;
      gap        <= '0;
`endif
    end else begin
      VEND <= 1'b0;
`ifdef CHANGE_RETURN_EN
      RET_NICKEL <= 1'b0;
      RET_DIME   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (coin_ev) begin
            CREDIT <= coin_val;
            state  <= ST_ACCUM;
          end
        end

        ST_ACCUM: begin
          if (coin_ev) begin
            if (sum >= PRICE_V) begin
              CREDIT <= CREDIT_W'(sum - PRICE_V);
              state  <= ST_VEND;
              VEND   <= 1'b1;
              BUSY   <= 1'b1;
            end else begin
              CREDIT <= CREDIT_W'(sum);
            end
          end else if (cancel_ev) begin
`ifdef CHANGE_RETURN_EN
            state <= ST_CHANGE;
            BUSY  <= 1'b1;
            gap   <= '0;
`else
            CREDIT <= '0;
            state  <= ST_IDLE;
`endif
          end
        end

        ST_VEND: begin
`ifdef CHANGE_RETURN_EN
          if (CREDIT != '0) begin
            state <= ST_CHANGE;
            gap   <= '0;
          end else begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
`else
          // Without change return the machine keeps any excess.
          CREDIT <= '0;
          state  <= ST_IDLE;
          BUSY   <= 1'b0;
`endif
        end

`ifdef CHANGE_RETURN_EN
        ST_CHANGE: begin
          if (gap != '0) begin
            gap <= gap - 4'd1;
          end else begin
            if (CREDIT >= DIME_C) RET_DIME   <= 1'b1;
            else                  RET_NICKEL <= 1'b1;
            CREDIT <= CREDIT - ret_val;
            if (CREDIT == ret_val) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end else begin
              gap <= 4'(RET_GAP);
            end
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: expected output pulses are queued with stimulus
// and matched by a monitor; credit and busy are checked inline by each scenario task.
module tb_vend_controller;
  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       nickel = 1'b0;
  logic       dime = 1'b0;
  logic       quarter = 1'b0;
  logic       cancel_in = 1'b0;
  logic       vend;
  logic       ret_nickel;
  logic       ret_dime;
  logic [6:0] credit;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_pulse = 0;

  localparam logic [3:0] P_N = 4'b0001;
  localparam logic [3:0] P_D = 4'b0010;
  localparam logic [3:0] P_Q = 4'b0100;
  localparam logic [3:0] P_C = 4'b1000;
  localparam logic [2:0] E_V = 3'b100;
  localparam logic [2:0] E_D = 3'b010;
  localparam logic [2:0] E_N = 3'b001;

  typedef struct {
    logic [2:0] code;
    int         gap;
  } exp_t;

  exp_t exp_q[$];

  vend_controller #(.PRICE(35), .RET_GAP(3)) dut (
    .CLK50M     (clk),
    .nRST       (nrst),
    .NICKEL     (nickel),
    .DIME       (dime),
    .QUARTER    (quarter),
    .CANCEL     (cancel_in),
    .VEND       (vend),
    .RET_NICKEL (ret_nickel),
    .RET_DIME   (ret_dime),
    .CREDIT     (credit),
    .BUSY       (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every output pulse pops one expectation (kind plus optional idle gap).
  always @(negedge clk) begin : mon
    exp_t e;
    logic [2:0] obs;
    obs = {vend, ret_dime, ret_nickel};
    if (nrst === 1'b1 && obs !== 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: observed {vend,ret_dime,ret_nickel}=%b, required none", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.code) begin
          errors++;
          $display("FAIL pulse_kind: observed %b, required %b", obs, e.code);
        end else begin
          $display("pulse %b at cycle %0d", obs, cyc);
        end
        if (e.gap >= 0) begin
          checks++;
          if (cyc - last_pulse - 1 != e.gap) begin
            errors++;
            $display("FAIL pulse_gap: observed %0d idle cycles, required %0d", cyc - last_pulse - 1, e.gap);
          end
        end
      end
      last_pulse = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  function automatic void push_exp(input logic [2:0] code, input int gap);
    exp_t e;
    e.code = code;
    e.gap  = gap;
    exp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [3:0] pins);
    {cancel_in, quarter, dime, nickel} = pins;
    tick(3);
    {cancel_in, quarter, dime, nickel} = 4'b0000;
    tick(3);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected pulses missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    tick(2);
    #2 nrst = 1'b0;
    #1;
    checks++; if (credit !== 7'd0) begin errors++; $display("FAIL reset_credit: got %0d, required 0", credit); end
    checks++; if (vend !== 1'b0) begin errors++; $display("FAIL reset_vend: got %b, required 0", vend); end
    checks++; if (ret_nickel !== 1'b0) begin errors++; $display("FAIL reset_ret_nickel: got %b, required 0", ret_nickel); end
    checks++; if (ret_dime !== 1'b0) begin errors++; $display("FAIL reset_ret_dime: got %b, required 0", ret_dime); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tick(3);
    nrst = 1'b1;
    tick(4);
    $display("reset done: credit=%0d busy=%b", credit, busy);
  endtask

  task automatic test_vend_exact;
    quarter = 1'b1;
    tick(2);
    checks++; if (credit !== 7'd0) begin errors++; $display("FAIL latency_early: credit %0d, required 0", credit); end
    tick(1);
    checks++; if (credit !== 7'd25) begin errors++; $display("FAIL latency_3cyc: credit %0d, required 25", credit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL accum_busy: got %b, required 0", busy); end
    quarter = 1'b0;
    tick(3);
    push_exp(E_V, -1);
    coin(P_D);
    drain("vend_exact");
    tick(8);
    checks++; if (credit !== 7'd0) begin errors++; $display("FAIL vend_exact_credit: got %0d, required 0", credit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vend_exact_busy: got %b, required 0", busy); end
    $display("vend exact: credit=%0d", credit);
  endtask

  task automatic test_change;
    coin(P_Q);
    checks++; if (credit !== 7'd25) begin errors++; $display("FAIL change_first_q: credit %0d, required 25", credit); end
`ifdef CHANGE_RETURN_EN
    push_exp(E_V, -1);
    push_exp(E_D, -1);
    push_exp(E_N, 3);
    quarter = 1'b1;
    tick(3);
    // This nickel's event lands while change is being paid and must be discarded.
    quarter = 1'b0;
    nickel  = 1'b1;
    tick(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL change_busy: got %b, required 1", busy); end
    nickel = 1'b0;
`else
    push_exp(E_V, -1);
    coin(P_Q);
`endif
    drain("change");
    tick(8);
    checks++; if (credit !== 7'd0) begin errors++; $display("FAIL change_credit: got %0d, required 0", credit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL change_busy_end: got %b, required 0", busy); end
    $display("quarter+quarter: credit=%0d", credit);
  endtask

  task automatic test_cancel;
    coin(P_N);
    checks++; if (credit !== 7'd5) begin errors++; $display("FAIL cancel_pre: credit %0d, required 5", credit); end
`ifdef CHANGE_RETURN_EN
    push_exp(E_N, -1);
`endif
    coin(P_C);
    drain("cancel");
    tick(6);
    checks++; if (credit !== 7'd0) begin errors++; $display("FAIL cancel_credit: got %0d, required 0", credit); end
    $display("nickel+cancel: credit=%0d", credit);
  endtask

  task automatic test_simultaneous;
    coin(P_D | P_Q);
    checks++; if (credit !== 7'd25) begin errors++; $display("FAIL simul_coin: credit %0d, required 25", credit); end
    coin(P_C | P_N);
    checks++; if (credit !== 7'd30) begin errors++; $display("FAIL cancel_with_coin: credit %0d, required 30", credit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_with_coin_busy: got %b, required 0", busy); end
`ifdef CHANGE_RETURN_EN
    push_exp(E_D, -1);
    push_exp(E_D, 3);
    push_exp(E_D, 3);
`endif
    coin(P_C);
    drain("simul_cancel");
    tick(6);
    checks++; if (credit !== 7'd0) begin errors++; $display("FAIL simul_credit_end: got %0d, required 0", credit); end
    $display("simultaneous coins: credit=%0d", credit);
  endtask

  task automatic test_back_to_back;
    coin(P_N);
    checks++; if (credit !== 7'd5) begin errors++; $display("FAIL b2b_n1: credit %0d, required 5", credit); end
    coin(P_N);
    checks++; if (credit !== 7'd10) begin errors++; $display("FAIL b2b_n2: credit %0d, required 10", credit); end
    coin(P_D);
    checks++; if (credit !== 7'd20) begin errors++; $display("FAIL b2b_d: credit %0d, required 20", credit); end
    push_exp(E_V, -1);
`ifdef CHANGE_RETURN_EN
    push_exp(E_D, -1);
`endif
    coin(P_Q);
    drain("b2b");
    tick(6);
    checks++; if (credit !== 7'd0) begin errors++; $display("FAIL b2b_end: credit %0d, required 0", credit); end
    $display("back to back: credit=%0d", credit);
  endtask

  task automatic test_reset_mid_change;
    int n;
    coin(P_Q);
`ifdef CHANGE_RETURN_EN
    push_exp(E_D, -1);
    cancel_in = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL first_change_pulse: %0d pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
    cancel_in = 1'b0;
`else
    coin(P_C);
`endif
    quarter = 1'b1;
    #2 nrst = 1'b0;
    #1;
    checks++; if (credit !== 7'd0) begin errors++; $display("FAIL midreset_credit: got %0d, required 0", credit); end
    tick(2);
    nrst = 1'b1;
    tick(10);
    checks++; if (credit !== 7'd0) begin errors++; $display("FAIL held_quarter: credit %0d, required 0", credit); end
    quarter = 1'b0;
    tick(4);
    checks++; if (credit !== 7'd0) begin errors++; $display("FAIL held_quarter_release: credit %0d, required 0", credit); end
    coin(P_Q);
    checks++; if (credit !== 7'd25) begin errors++; $display("FAIL rearmed_quarter: credit %0d, required 25", credit); end
    #2 nrst = 1'b0;
    tick(1);
    nrst = 1'b1;
    tick(4);
    $display("reset mid change: credit=%0d", credit);
  endtask

  initial begin
    test_reset();
    test_vend_exact();
    test_change();
    test_cancel();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_change();
    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter PRICE, default 35, item price in cents; SHALL be a multiple of 5 in 5..100.
REQ-002 Parameter RET_GAP, default 3, idle cycles between successive change pulses; SHALL be 1..15.
REQ-003 CLK50M  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-004 nRST  input  1  reset, asynchronous and active-low.
REQ-005 NICKEL  input  1  debounced level, high while the 5-cent coin switch is active.
REQ-006 DIME  input  1  debounced level, 10-cent coin.
REQ-007 QUARTER  input  1  debounced level, 25-cent coin.
REQ-008 CANCEL  input  1  debounced level, customer cancel request.
REQ-009 VEND  output  1  one-cycle pulse that dispenses the item.
REQ-010 RET_NICKEL  output  1  one-cycle pulse that returns a 5-cent coin.
REQ-011 RET_DIME  output  1  one-cycle pulse that returns a 10-cent coin.
REQ-012 CREDIT  output  7  current accumulated credit in cents, unsigned.
REQ-013 BUSY  output  1  high in VEND and CHANGE states; coins are ignored while high.

Function
REQ-014 Every level input SHALL pass through a 2-flop synchronizer followed by rising-edge detection, giving one event per low-to-high transition; a held input generates no further events.
REQ-015 The FSM SHALL have states IDLE, ACCUM, VEND, CHANGE.
REQ-016 IDLE, on a coin event: add the coin value to CREDIT and go to ACCUM.
REQ-017 Coin events arriving in the same cycle: accept only the highest value (QUARTER > DIME > NICKEL) and drop the rest.
REQ-018 ACCUM, coin event with CREDIT + value >= PRICE: go to VEND with CREDIT = CREDIT + value - PRICE. Otherwise, add the value and stay in ACCUM.
REQ-019 VEND: assert VEND for exactly one cycle. Next state is CHANGE if CREDIT > 0, else IDLE.
REQ-020 ACCUM, CANCEL event with no coin event in the same cycle: go to CHANGE with CREDIT unchanged.
REQ-021 CANCEL and coin event in the same cycle: the coin SHALL be processed and the CANCEL dropped.
REQ-022 CANCEL event in IDLE, VEND or CHANGE SHALL be ignored.
REQ-023 CHANGE: emit RET_DIME if CREDIT >= 10, else RET_NICKEL. Subtract the returned value, then wait RET_GAP cycles before the next pulse.
REQ-024 CHANGE: when CREDIT reaches 0, return to IDLE immediately after the last pulse; no trailing gap.
REQ-025 Coin events during VEND or CHANGE SHALL be discarded and SHALL NOT alter CREDIT (BUSY high).
REQ-026 Latency: output pulses SHALL occur at most 1 cycle after the state change that requires them. Input pin edge to CREDIT update SHALL be exactly 3 cycles.
REQ-027 CREDIT arithmetic SHALL be 7-bit unsigned. The maximum reachable value is PRICE+20, so it never overflows.
REQ-028 VEND, RET_NICKEL and RET_DIME SHALL be mutually exclusive in every cycle.

Reset
REQ-029 nRST low SHALL immediately force state IDLE, CREDIT=0, VEND=RET_NICKEL=RET_DIME=BUSY=0, and clear the synchronizers, edge history and gap counter.
REQ-030 Reset asserted mid-CHANGE SHALL abandon the remaining change without further pulses.
REQ-031 Inputs held high across reset release SHALL NOT generate an event until they go low and then high again.

Configuration
REQ-032 Macro CHANGE_RETURN_EN.
- Defined: behaviour is as described under Function.
- Undefined: CHANGE state, RET_NICKEL/RET_DIME pulses and the gap counter are removed; the outputs are tied to 0.
- Undefined, VEND: CREDIT is cleared to 0 and the FSM returns to IDLE (excess credit is kept by the machine).
- Undefined, CANCEL event in ACCUM: clears CREDIT and goes to IDLE.

Structure
REQ-033 Package vend_pkg SHALL hold:
- the state enum type;
- coin value constants NICKEL_C=5, DIME_C=10, QUARTER_C=25;
- the CREDIT width constant.
REQ-034 One sub-module, edge_sync (2-flop synchronizer plus rising-edge pulse, ports CLK50M/nRST/A/PULSE), SHALL be instantiated once per level input.

Verification
REQ-035 PRICE=35: QUARTER then DIME -> one VEND pulse, CREDIT=0, no return pulses, back to IDLE.
REQ-036 PRICE=35: QUARTER, QUARTER -> VEND, then RET_DIME, 3 idle cycles, RET_NICKEL, then IDLE with CREDIT=0.
REQ-037 NICKEL then CANCEL -> RET_NICKEL once, CREDIT 5->0, no VEND.
REQ-038 DIME and QUARTER rising in the same cycle from IDLE -> CREDIT=25; DIME dropped.
REQ-039 Reset pulse after the first of three change pulses -> no further pulses, CREDIT=0; QUARTER held through reset release produces no credit.
REQ-040 CHANGE_RETURN_EN undefined, PRICE=35: QUARTER, QUARTER -> VEND, CREDIT=0, RET_* never asserted.
